// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
//   Parametrised Mealy serial-pattern detector with a runtime-loadable
//   pattern, an overlap/non-overlap mode, an input-valid qualifier and a
//   saturating match counter.
//
// Parameters
//   PAT_LEN  pattern length in bits (2..16)
//   PAT_RST  pattern register value after reset (PAT_LEN bits)
//   CNT_W    match counter width
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous, active-high; clears all state immediately
//   in_seq       serial data bit
//   in_valid     in_seq is consumed on a rising edge only when high
//   overlap_en   1 = overlapping matches; 0 = history restarts after a match
//   load_pat     single-cycle strobe, loads pat_in (same-cycle bit dropped)
//   pat_in       new pattern, bit PAT_LEN-1 is the first bit received
//   clr_cnt      synchronous clear of match_count, wins over a match
//   out_seq      combinational Mealy match flag, same cycle as the last bit
//   match_count  registered, saturating count of matches
// ---------------------------------------------------------------------------
module seq_detect_param #(
  parameter int                 PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PAT_RST = 3'b001,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_seq,
  input  logic               in_valid,
  input  logic               overlap_en,
  input  logic               load_pat,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               clr_cnt,
  output logic               out_seq,
  output logic [CNT_W-1:0]   match_count
);

  localparam int FILL_W = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] pat;
  logic [PAT_LEN-2:0] hist;
  logic [FILL_W-1:0]  fill;

  logic               accept;
  logic               match;
  logic [PAT_LEN-1:0] window;

  // Candidate window: stored history followed by the bit arriving now.
  // Its low PAT_LEN-1 bits are also the next history value, which keeps
  // the shift well-formed for PAT_LEN = 2.
  always_comb begin
    window = {hist, in_seq};
    accept = in_valid & ~load_pat;
    match  = accept & (fill == FILL_MAX) & (window == pat);
  end

  assign out_seq = match;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat  <= PAT_RST;
      hist <= '0;
      fill <= '0;
    end else if (load_pat) begin
      pat  <= pat_in;
      hist <= '0;
      fill <= '0;
    end else if (in_valid) begin
      hist <= window[PAT_LEN-2:0];
      if (match && !overlap_en) begin
        fill <= '0;
      end else if (fill != FILL_MAX) begin
        fill <= fill + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_count <= '0;
    end else if (clr_cnt) begin
      match_count <= '0;
    end else if (match && (match_count != '1)) begin
      match_count <= match_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_param
//   Directed bench for seq_detect_param. Two instances share all stimulus:
//   dut8 uses the defaults (PAT_LEN=3, CNT_W=8), dut2 uses CNT_W=2 to reach
//   counter saturation quickly. Inputs change on the falling edge; out_seq
//   is sampled 1 ns later, match_count on the following falling edge.
// ---------------------------------------------------------------------------
module tb_seq_detect_param;

  logic       clk;
  logic       reset;
  logic       in_seq;
  logic       in_valid;
  logic       overlap_en;
  logic       load_pat;
  logic [2:0] pat_in;
  logic       clr_cnt;
  logic       out8;
  logic       out2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int unsigned n_checks;
  int unsigned n_fail;

  seq_detect_param #(.PAT_LEN(3), .PAT_RST(3'b001), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .in_seq(in_seq), .in_valid(in_valid),
    .overlap_en(overlap_en), .load_pat(load_pat), .pat_in(pat_in),
    .clr_cnt(clr_cnt), .out_seq(out8), .match_count(cnt8)
  );

  seq_detect_param #(.PAT_LEN(3), .PAT_RST(3'b001), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_seq(in_seq), .in_valid(in_valid),
    .overlap_en(overlap_en), .load_pat(load_pat), .pat_in(pat_in),
    .clr_cnt(clr_cnt), .out_seq(out2), .match_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Present one bit on the falling edge and check the Mealy flag of dut8.
  task automatic bit_in(input logic v, input logic b, input logic exp_out, input string tag);
    @(negedge clk);
    in_valid = v;
    in_seq   = b;
    #1;
    check(tag, {31'd0, out8}, {31'd0, exp_out});
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_seq   = 1'b0;
    load_pat = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  task automatic load(input logic [2:0] p, input logic c);
    @(negedge clk);
    in_valid = 1'b0;
    load_pat = 1'b1;
    pat_in   = p;
    clr_cnt  = c;
    @(negedge clk);
    load_pat = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    in_seq     = 1'b0;
    in_valid   = 1'b0;
    overlap_en = 1'b0;
    load_pat   = 1'b0;
    pat_in     = 3'b000;
    clr_cnt    = 1'b0;

    #12;
    check("rst_out", {31'd0, out8}, 32'd0);
    check("rst_cnt", {24'd0, cnt8}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Default pattern 001, non-overlap
    bit_in(1, 0, 0, "t1_b1");
    bit_in(1, 0, 0, "t1_b2");
    bit_in(1, 1, 1, "t1_b3");
    idle();
    check("t1_cnt", {24'd0, cnt8}, 32'd1);

    // Pattern 101, overlap: matches on bits 3 and 5
    overlap_en = 1'b1;
    load(3'b101, 1'b1);
    bit_in(1, 1, 0, "t2o_b1");
    bit_in(1, 0, 0, "t2o_b2");
    bit_in(1, 1, 1, "t2o_b3");
    bit_in(1, 0, 0, "t2o_b4");
    bit_in(1, 1, 1, "t2o_b5");
    idle();
    check("t2o_cnt", {24'd0, cnt8}, 32'd2);

    // Same stream, non-overlap: match on bit 3 only
    overlap_en = 1'b0;
    load(3'b101, 1'b1);
    bit_in(1, 1, 0, "t2n_b1");
    bit_in(1, 0, 0, "t2n_b2");
    bit_in(1, 1, 1, "t2n_b3");
    bit_in(1, 0, 0, "t2n_b4");
    bit_in(1, 1, 0, "t2n_b5");
    idle();
    check("t2n_cnt", {24'd0, cnt8}, 32'd1);

    // Gapped input with default pattern; in_seq=1 during gaps must be ignored
    load(3'b001, 1'b1);
    bit_in(1, 0, 0, "t3_b1");
    bit_in(0, 1, 0, "t3_gap1");
    bit_in(0, 1, 0, "t3_gap2");
    bit_in(0, 1, 0, "t3_gap3");
    bit_in(1, 0, 0, "t3_b2");
    bit_in(0, 1, 0, "t3_gap4");
    bit_in(1, 1, 1, "t3_b3");
    idle();
    check("t3_cnt", {24'd0, cnt8}, 32'd1);

    // Sliding history: 0,0,0,1 matches on the 4th bit
    bit_in(1, 0, 0, "t4_b1");
    bit_in(1, 0, 0, "t4_b2");
    bit_in(1, 0, 0, "t4_b3");
    bit_in(1, 1, 1, "t4_b4");
    idle();
    check("t4_cnt", {24'd0, cnt8}, 32'd2);

    // load_pat mid-pattern with a completing bit in the same cycle
    bit_in(1, 0, 0, "t5_b1");
    bit_in(1, 0, 0, "t5_b2");
    @(negedge clk);
    in_valid = 1'b1;
    in_seq   = 1'b1;
    load_pat = 1'b1;
    pat_in   = 3'b001;
    #1;
    check("t5_load_out", {31'd0, out8}, 32'd0);
    @(negedge clk);
    load_pat = 1'b0;
    in_valid = 1'b0;
    check("t5_load_cnt", {24'd0, cnt8}, 32'd2);
    bit_in(1, 1, 0, "t5_a1");
    bit_in(1, 0, 0, "t5_a2");
    bit_in(1, 0, 0, "t5_a3");
    bit_in(1, 1, 1, "t5_a4");
    idle();
    check("t5_cnt", {24'd0, cnt8}, 32'd3);

    // Saturation on the 2-bit counter: pattern 000, overlap, 7 zeros
    overlap_en = 1'b1;
    load(3'b000, 1'b1);
    for (int i = 0; i < 7; i++) begin
      bit_in(1, 0, (i >= 2) ? 1'b1 : 1'b0, $sformatf("t6_b%0d", i + 1));
    end
    idle();
    check("t6_cnt2_sat", {30'd0, cnt2}, 32'd3);
    check("t6_cnt8", {24'd0, cnt8}, 32'd5);

    // clr_cnt on a match cycle wins over the increment
    @(negedge clk);
    in_valid = 1'b1;
    in_seq   = 1'b0;
    clr_cnt  = 1'b1;
    #1;
    check("t6_clr_out", {31'd0, out2}, 32'd1);
    idle();
    check("t6_clr_cnt2", {30'd0, cnt2}, 32'd0);
    check("t6_clr_cnt8", {24'd0, cnt8}, 32'd0);
    bit_in(1, 0, 1, "t6_post");
    idle();
    check("t6_post_cnt2", {30'd0, cnt2}, 32'd1);

    // Async reset mid-stream clears outputs before any clock edge
    @(negedge clk);
    in_valid = 1'b1;
    in_seq   = 1'b0;
    #1;
    check("t7_pre_out", {31'd0, out2}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("t7_rst_out", {31'd0, out2}, 32'd0);
    check("t7_rst_cnt2", {30'd0, cnt2}, 32'd0);
    check("t7_rst_cnt8", {24'd0, cnt8}, 32'd0);
    idle();
    reset      = 1'b0;
    overlap_en = 1'b0;
    // Pattern back to 001 and detection restarts from an empty history
    bit_in(1, 0, 0, "t7_b1");
    bit_in(1, 0, 0, "t7_b2");
    bit_in(1, 1, 1, "t7_b3");
    idle();
    check("t7_cnt", {24'd0, cnt8}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised Mealy serial-pattern detector; successor to the fixed 3-bit "001" detector.
- Adds: runtime-loadable pattern of PAT_LEN bits, overlap/non-overlap mode, input-valid qualifier, saturating match counter.
- Sits on a serial bit stream; out_seq is a combinational Mealy flag in the same cycle as the completing bit.

Parameters:
- PAT_LEN, 3, pattern length in bits (2..16).
- PAT_RST, 3'b001, pattern register value after reset; PAT_LEN bits wide.
- CNT_W, 8, match counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_seq  input  1  serial data bit.
- in_valid  input  1  in_seq is consumed on a rising edge only when high.
- overlap_en  input  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- load_pat  input  1  single-cycle strobe; loads pat_in.
- pat_in  input  PAT_LEN  new pattern; bit PAT_LEN-1 is the first bit received.
- clr_cnt  input  1  synchronous clear of match_count.
- out_seq  output  1  Mealy match flag, combinational.
- match_count  output  CNT_W  registered, saturating count of matches.

Behaviour:
- State: pattern reg pat, history shift reg hist (PAT_LEN-1 bits, newest in bit 0), fill counter fill (0..PAT_LEN-1), match_count.
- Reset (async): pat = PAT_RST, hist = 0, fill = 0, match_count = 0. out_seq then depends only on inputs and is 0 because fill = 0 (PAT_LEN >= 2).
- Match condition: match = in_valid & ~load_pat & (fill == PAT_LEN-1) & ({hist, in_seq} == pat).
- out_seq = match, combinational, zero latency.
- Accepted bit (in_valid & ~load_pat): hist <= {hist[PAT_LEN-3:0], in_seq}. fill increments and saturates at PAT_LEN-1.
- On match with overlap_en = 0: fill <= 0. The next match needs PAT_LEN fresh bits.
- On match with overlap_en = 1: fill stays at PAT_LEN-1.
- in_valid = 0: hist, fill and match_count hold; out_seq = 0.
- load_pat = 1: pat <= pat_in, hist <= 0, fill <= 0.
  - A same-cycle in_seq is discarded and out_seq = 0.
  - The new pattern applies from the next cycle.
- overlap_en is sampled each cycle. Changing it mid-stream does not clear history.
- match_count:
  - Increments by 1 on each match.
  - Saturates at 2^CNT_W - 1 and never wraps.
  - clr_cnt forces it to 0 and wins over a same-cycle match.
- Reset asserted mid-pattern: partial history is lost. After release, detection restarts from fill = 0.

Test Plan:
- Default pattern, overlap_en=0: after reset, drive valid bits 0,0,1 -> out_seq=1 only on the third bit; match_count=1 next cycle.
- overlap_en=1, pat_in=3'b101 loaded, stream 1,0,1,0,1 -> out_seq high on bits 3 and 5; match_count=2. Same stream with overlap_en=0 -> high on bit 3 only; count=1.
- Gapped input: 0, (in_valid=0 x3), 0, (in_valid=0), 1 with default pattern -> single match on the final bit; out_seq=0 during the gaps.
- Stream 0,0,0,1 with default pattern -> out_seq=1 on the 4th bit. This checks sliding history, not naive state reset.
- load_pat with in_valid=1 in the same cycle mid-pattern -> no match that cycle; fill=0; a fresh full pattern is required afterwards.
- CNT_W=2, overlap_en=1, pattern 3'b000, stream of 7 zeros -> count saturates at 3. clr_cnt asserted on a match cycle -> count=0. Async reset mid-stream -> outputs clear without a clock edge.
